// File: rtl/fpi_issue_ctrl.sv
// FP issue control: decodes OP-FP, tracks in-flight destinations and reserves the single writeback port.
// Optional FPI_WB_BYPASS_EN: a register being written back this cycle counts as not pending.
module fpi_issue_ctrl #(
    parameter int REG_W    = 5,
    parameter int LAT_ADD  = 3,
    parameter int LAT_MUL  = 4,
    parameter int LAT_DIV  = 12,
    parameter int LAT_SQRT = 16,
    parameter int MAX_LAT  = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       op,
    input  logic [6:0]       funct7,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    output logic             illegal,
    output logic             fpu_start,
    output logic [3:0]       fpu_cont,
    output logic [REG_W-1:0] fpu_rd,
    output logic             divsqrt_busy,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd
);
    localparam int NREG  = 2**REG_W;
    localparam int CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic { DS_IDLE, DS_BUSY } ds_state_e;

    ds_state_e                       ds_state_q, ds_state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NREG-1:0]                 pending_q, pending_d;
    logic [MAX_LAT:1]                resv_vld_q, resv_vld_d;
    logic [MAX_LAT:1][REG_W-1:0]     resv_rd_q, resv_rd_d;
    logic                            wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]                wb_rd_q, wb_rd_d;
    logic                            illegal_q, illegal_d;
    logic                            fpu_start_q, fpu_start_d;
    logic [3:0]                      fpu_cont_q, fpu_cont_d;
    logic [REG_W-1:0]                fpu_rd_q, fpu_rd_d;

    logic            is_fp, legal, is_ds, uses_rs2, slot_busy, ds_free, hazard, issue;
    logic [3:0]      cont;
    int              lat;
    logic [NREG-1:0] pend_vis;
    logic            unused_fmt;

    assign unused_fmt = ^funct7[1:0];

    always_comb begin
        is_fp    = (op == 7'b1010011);
        legal    = 1'b1;
        is_ds    = 1'b0;
        uses_rs2 = 1'b1;
        cont     = 4'b0000;
        lat      = LAT_ADD;
        case (funct7[6:2])
            5'b00000: cont = 4'b1000;
            5'b00001: cont = 4'b1001;
            5'b00010: begin cont = 4'b1010; lat = LAT_MUL; end
            5'b00011: begin cont = 4'b1011; lat = LAT_DIV; is_ds = 1'b1; end
            5'b01011: begin cont = 4'b1100; lat = LAT_SQRT; is_ds = 1'b1; uses_rs2 = 1'b0; end
            default:  legal = 1'b0;
        endcase

        pend_vis = pending_q;
`ifdef FPI_WB_BYPASS_EN
        if (wb_valid_q) pend_vis[wb_rd_q] = 1'b0;
`endif

        // The slot that becomes cycle T+L next cycle is the one currently at resv[L].
        slot_busy = 1'b0;
        for (int i = 1; i <= MAX_LAT; i++) begin
            if (i == lat && resv_vld_q[i]) slot_busy = 1'b1;
        end

        // The unit frees up in the cycle its result writes back, so a follow-on may issue then.
        ds_free = (ds_state_q == DS_IDLE) || (cnt_q == '0);
        hazard  = pend_vis[rs1] || (uses_rs2 && pend_vis[rs2]) || pend_vis[rd] ||
                  slot_busy || (is_ds && !ds_free);

        in_ready = !(in_valid && is_fp && legal && hazard);
        issue    = in_valid && is_fp && legal && !hazard;

        illegal_d   = in_valid && is_fp && !legal;
        fpu_start_d = issue;
        fpu_cont_d  = issue ? cont : 4'b0000;
        fpu_rd_d    = issue ? rd : '0;

        for (int i = 1; i < MAX_LAT; i++) begin
            resv_vld_d[i] = resv_vld_q[i+1];
            resv_rd_d[i]  = resv_rd_q[i+1];
        end
        resv_vld_d[MAX_LAT] = 1'b0;
        resv_rd_d[MAX_LAT]  = '0;
        if (issue) begin
            for (int i = 1; i < MAX_LAT; i++) begin
                if (i == lat - 1) begin
                    resv_vld_d[i] = 1'b1;
                    resv_rd_d[i]  = rd;
                end
            end
        end

        wb_valid_d = resv_vld_q[1] || (issue && lat == 1);
        wb_rd_d    = (issue && lat == 1) ? rd : resv_rd_q[1];

        // Clear first so a same-cycle set of the same register wins.
        pending_d = pending_q;
        if (wb_valid_q) pending_d[wb_rd_q] = 1'b0;
        if (issue)      pending_d[rd]      = 1'b1;

        ds_state_d = ds_state_q;
        cnt_d      = cnt_q;
        if (issue && is_ds) begin
            ds_state_d = DS_BUSY;
            cnt_d      = CNT_W'(lat - 1);
        end else if (ds_state_q == DS_BUSY) begin
            if (cnt_q == '0) ds_state_d = DS_IDLE;
            else             cnt_d      = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ds_state_q  <= DS_IDLE;
            cnt_q       <= '0;
            pending_q   <= '0;
            resv_vld_q  <= '0;
            resv_rd_q   <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            illegal_q   <= 1'b0;
            fpu_start_q <= 1'b0;
            fpu_cont_q  <= 4'b0000;
            fpu_rd_q    <= '0;
        end else begin
            ds_state_q  <= ds_state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            resv_vld_q  <= resv_vld_d;
            resv_rd_q   <= resv_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            illegal_q   <= illegal_d;
            fpu_start_q <= fpu_start_d;
            fpu_cont_q  <= fpu_cont_d;
            fpu_rd_q    <= fpu_rd_d;
        end
    end

    assign illegal      = illegal_q;
    assign fpu_start    = fpu_start_q;
    assign fpu_cont     = fpu_cont_q;
    assign fpu_rd       = fpu_rd_q;
    assign divsqrt_busy = (ds_state_q == DS_BUSY);
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
endmodule
